// File: rtl/delay_line_var.sv
// Variable-length WIDTH-bit delay line with valid qualifier and settle indicator.
// Optional build macro DELAY_LINE_FLUSH_EN: clear stages 1..MAX_DELAY whenever the delay changes.
module delay_line_var #(
   parameter int unsigned WIDTH     = 8,
   parameter int unsigned MAX_DELAY = 15,
   localparam int unsigned DW       = $clog2(MAX_DELAY + 1)
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             valid_i,
   input  logic [DW-1:0]    delay_i,
   output logic [WIDTH-1:0] data_o,
   output logic             valid_o,
   output logic             settled_o
);

   localparam logic [DW-1:0] MAX_C = DW'(MAX_DELAY);

   logic [WIDTH-1:0] sr [MAX_DELAY+1];
   logic [MAX_DELAY:0] vld;
   logic [DW-1:0]      delay_q;
   logic [DW-1:0]      delay_c;
   logic [DW:0]        cnt;
   logic [DW:0]        settle_lim;
   logic               chg;

   always_comb begin
      delay_c    = (delay_i > MAX_C) ? MAX_C : delay_i;
      chg        = (delay_c != delay_q) && !rst_i;
      settle_lim = {1'b0, delay_q} + (DW+1)'(1);
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int unsigned k = 0; k <= MAX_DELAY; k++) sr[k] <= '0;
         vld     <= '0;
         cnt     <= '0;
         delay_q <= delay_c;
      end else begin
         sr[0] <= data_i;
`ifdef DELAY_LINE_FLUSH_EN
         // Stage 0 still captures this edge's input; only older words are dropped.
         if (chg) begin
            for (int unsigned k = 1; k <= MAX_DELAY; k++) sr[k] <= '0;
            vld <= {{MAX_DELAY{1'b0}}, valid_i};
         end else begin
            for (int unsigned k = 1; k <= MAX_DELAY; k++) sr[k] <= sr[k-1];
            vld <= {vld[MAX_DELAY-1:0], valid_i};
         end
`else
         for (int unsigned k = 1; k <= MAX_DELAY; k++) sr[k] <= sr[k-1];
         vld <= {vld[MAX_DELAY-1:0], valid_i};
`endif
         if (chg) begin
            delay_q <= delay_c;
            cnt     <= '0;
         end else if (cnt != settle_lim) begin
            cnt <= cnt + (DW+1)'(1);
         end
      end
   end

   always_comb begin
      data_o    = sr[delay_q];
      valid_o   = vld[delay_q];
      settled_o = (cnt == settle_lim);
   end

endmodule

// File: tb/tb_delay_line_var.sv
// Randomised scoreboard bench for delay_line_var; the reference model predicts each output
// from the input history and the reset/change history rather than from stage contents.
module tb_delay_line_var;

   localparam int unsigned WIDTH     = 8;
   localparam int unsigned MAX_DELAY = 10;
   localparam int unsigned DW        = $clog2(MAX_DELAY + 1);

   logic             clk = 1'b0;
   logic             rst_i;
   logic [WIDTH-1:0] data_i;
   logic             valid_i;
   logic [DW-1:0]    delay_i;
   logic [WIDTH-1:0] data_o;
   logic             valid_o;
   logic             settled_o;

   always #5 clk = ~clk;

   delay_line_var #(.WIDTH(WIDTH), .MAX_DELAY(MAX_DELAY)) dut (
      .clk_i     (clk),
      .rst_i     (rst_i),
      .data_i    (data_i),
      .valid_i   (valid_i),
      .delay_i   (delay_i),
      .data_o    (data_o),
      .valid_o   (valid_o),
      .settled_o (settled_o)
   );

   typedef struct {
      int unsigned d;
      bit          v;
      bit          s;
      int          edge_no;
   } exp_t;

   exp_t        sb[$];
   int unsigned hist_d[$];
   bit          hist_v[$];
   int          n = 0;
   int          last_rst = 0;
   int          last_flush = 0;
   int          epoch = 0;
   int          dq = 0;
   int          total = 0;
   int          bad = 0;

   task automatic chk(input string name, input int unsigned act, input int unsigned want, input int e);
      total++;
      if (act != want) begin
         bad++;
         $display("FAIL %s edge=%0d got=%0h want=%0h", name, e, act, want);
      end
   endtask

   // Drive one edge's inputs, predict the outputs seen after that edge, advance one clock.
   task automatic step(input bit r, input bit v, input int unsigned d, input int unsigned dl);
      int   cd;
      int   s;
      int   lo;
      exp_t e;
      rst_i   = r;
      valid_i = v;
      data_i  = WIDTH'(d);
      delay_i = DW'(dl);
      cd = (dl > MAX_DELAY) ? int'(MAX_DELAY) : int'(dl);
      if (r) begin
         last_rst = n;
         epoch    = n;
         dq       = cd;
      end else if (cd != dq) begin
         epoch = n;
         dq    = cd;
`ifdef DELAY_LINE_FLUSH_EN
         last_flush = n;
`endif
      end
      hist_d.push_back(r ? 0 : (d & ((1 << WIDTH) - 1)));
      hist_v.push_back(r ? 1'b0 : v);
      s  = n - dq;
      lo = last_rst + 1;
      if (last_flush > lo) lo = last_flush;
      if (s >= lo) begin
         e.d = hist_d[s];
         e.v = hist_v[s];
      end else begin
         e.d = 0;
         e.v = 1'b0;
      end
      e.s       = (n - epoch) >= (dq + 1);
      e.edge_no = n;
      sb.push_back(e);
      n++;
      @(negedge clk);
   endtask

   always @(negedge clk) begin : monitor
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         chk("valid_o",   int'(valid_o),   int'(e.v), e.edge_no);
         chk("settled_o", int'(settled_o), int'(e.s), e.edge_no);
         chk("data_o",    int'(data_o),    e.d,       e.edge_no);
      end
   end

   initial begin : stim
      int unsigned cur;
      rst_i = 1'b1; valid_i = 1'b0; data_i = '0; delay_i = '0;

      // Out-of-range request clamps to MAX_DELAY; five back-to-back words
      cur = 15;
      step(1, 0, 0, cur);
      step(1, 0, 0, cur);
      for (int i = 1; i <= 5; i++) step(0, 1, i, cur);
      for (int i = 0; i < 14; i++) step(0, 0, 0, cur);

      // Zero extra delay, single word
      cur = 0;
      step(0, 0, 0, cur);
      step(0, 1, 8'hA5, cur);
      for (int i = 0; i < 3; i++) step(0, 0, 0, cur);

      // Gapped valid pattern at delay 7
      cur = 7;
      step(0, 1, 8'h11, cur);
      step(0, 0, 8'h22, cur);
      step(0, 1, 8'h33, cur);
      step(0, 1, 8'h44, cur);
      step(0, 0, 8'h55, cur);
      for (int i = 0; i < 10; i++) step(0, 0, 0, cur);

      // Stream at delay 10, switch to 3 mid-stream
      cur = 10;
      for (int i = 0; i < 14; i++) step(0, 1, 8'h60 + i, cur);
      cur = 3;
      for (int i = 0; i < 8; i++) step(0, 1, 8'h80 + i, cur);
      for (int i = 0; i < 12; i++) step(0, 0, 0, cur);

      // Reset while five words are in flight
      cur = 10;
      for (int i = 0; i < 12; i++) step(0, 0, 0, cur);
      for (int i = 0; i < 5; i++) step(0, 1, 8'hC0 + i, cur);
      step(1, 0, 0, cur);
      step(1, 0, 0, cur);
      for (int i = 0; i < 14; i++) step(0, 0, 0, cur);

      // Delay toggling every cycle keeps settled_o low
      for (int i = 0; i < 20; i++) step(0, $urandom_range(0, 1), $urandom_range(0, 255), (i % 2) ? 2 : 5);
      cur = 5;

      // Random traffic with occasional resets and delay changes
      for (int i = 0; i < 1500; i++) begin
         if ($urandom_range(0, 19) == 0) cur = $urandom_range(0, 15);
         step($urandom_range(0, 99) == 0, $urandom_range(0, 1), $urandom_range(0, 255), cur);
      end

      for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() > 0) begin
         bad++;
         total++;
         $display("FAIL drain: got=%0d pending want=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
